// File: rtl/eprom_arb_pkg.sv
// Shared types and constants for the two-port EPROM controller arbiter.
package eprom_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

    localparam logic PORT_A = 1'b0;
    localparam logic PORT_B = 1'b1;

    localparam logic OP_WR = 1'b0;
    localparam logic OP_RD = 1'b1;

endpackage

// File: rtl/eprom_arbiter_if.sv
// Requester A/B command ports plus the eprom_controller command port, bundled.
interface eprom_arbiter_if;
    logic        a_wr, a_rd, a_margin;
    logic [31:0] a_data_in;
    logic        a_ack, a_wr_done, a_rd_done, a_err;
    logic [31:0] a_data_out;

    logic        b_wr, b_rd, b_margin;
    logic [31:0] b_data_in;
    logic        b_ack, b_wr_done, b_rd_done, b_err;
    logic [31:0] b_data_out;

    logic        ctl_wr, ctl_rd, ctl_margin;
    logic [31:0] ctl_data_in;
    logic        ctl_ack, ctl_wr_done, ctl_rd_done;
    logic [31:0] ctl_data_out;

    logic        busy;

    // Valid/ready contract: a request level (x_wr/x_rd) is held until x_ack;
    // ctl_wr/ctl_rd are held until ctl_ack; every *_done, *_ack and x_err is a
    // single-cycle pulse, and x_data_out is valid with x_rd_done and held.
    modport slave (
        input  a_wr, a_rd, a_margin, a_data_in,
        output a_ack, a_wr_done, a_rd_done, a_err, a_data_out,
        input  b_wr, b_rd, b_margin, b_data_in,
        output b_ack, b_wr_done, b_rd_done, b_err, b_data_out,
        output ctl_wr, ctl_rd, ctl_margin, ctl_data_in,
        input  ctl_ack, ctl_wr_done, ctl_rd_done, ctl_data_out,
        output busy
    );

    modport master (
        output a_wr, a_rd, a_margin, a_data_in,
        input  a_ack, a_wr_done, a_rd_done, a_err, a_data_out,
        output b_wr, b_rd, b_margin, b_data_in,
        input  b_ack, b_wr_done, b_rd_done, b_err, b_data_out,
        input  ctl_wr, ctl_rd, ctl_margin, ctl_data_in,
        output ctl_ack, ctl_wr_done, ctl_rd_done, ctl_data_out,
        input  busy
    );
endinterface

// File: rtl/eprom_arbiter_rr_arb2.sv
// Two-request round-robin: combinational grant, registered last-served port.
module rr_arb2
    import eprom_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_req_a,
    input  logic i_req_b,
    input  logic i_update,
    input  logic i_upd_port,
    output logic o_any,
    output logic o_gnt
);
    logic r_rr_last;

    // Reset to B so that A wins the very first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_rr_last <= PORT_B;
        else if (i_update)
            r_rr_last <= i_upd_port;
    end

    always_comb begin
        o_any = i_req_a | i_req_b;
        o_gnt = PORT_B;
        if (i_req_a && i_req_b)
            o_gnt = ~r_rr_last;
        else if (i_req_a)
            o_gnt = PORT_A;
    end
endmodule

// File: rtl/eprom_arbiter.sv
// Shares one eprom_controller between an auto-loader (A) and the I2C FSM (B):
// round-robin grant, one transaction in flight, watchdog abort.
module eprom_arbiter
    import eprom_arb_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_W           = 13
) (
    input  logic           clk,
    input  logic           rst,
    eprom_arbiter_if.slave bus,
    output arb_state_t     o_dbg_state
);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);

    arb_state_t      r_state, w_next_state;
    logic            r_gnt, r_op, r_margin;
    logic [31:0]     r_data;
    logic [TO_W-1:0] r_cnt;
    logic            r_mask_a, r_mask_b;
    logic            r_a_ack, r_a_wr_done, r_a_rd_done, r_a_err;
    logic            r_b_ack, r_b_wr_done, r_b_rd_done, r_b_err;
    logic [31:0]     r_a_data_out, r_b_data_out;

    logic            w_raw_a, w_raw_b, w_req_a, w_req_b, w_any, w_gnt;
    logic            w_sel_wr, w_sel_margin;
    logic [31:0]     w_sel_data;
    logic            w_done_match, w_ack_evt, w_done_evt, w_to_evt, w_cnt_exp;
    logic            w_ctl_wr, w_ctl_rd, w_ctl_margin, w_busy;
    logic [31:0]     w_ctl_data;

    assign w_raw_a = bus.a_wr | bus.a_rd;
    assign w_raw_b = bus.b_wr | bus.b_rd;
    // A port that was just acked stays masked until it drops its request.
    assign w_req_a = w_raw_a & ~r_mask_a;
    assign w_req_b = w_raw_b & ~r_mask_b;

    rr_arb2 u_rr (
        .clk        (clk),
        .rst        (rst),
        .i_req_a    (w_req_a),
        .i_req_b    (w_req_b),
        .i_update   (w_ack_evt | w_to_evt),
        .i_upd_port (r_gnt),
        .o_any      (w_any),
        .o_gnt      (w_gnt)
    );

    assign w_sel_wr     = (w_gnt == PORT_A) ? bus.a_wr      : bus.b_wr;
    assign w_sel_data   = (w_gnt == PORT_A) ? bus.a_data_in : bus.b_data_in;
    assign w_sel_margin = (w_gnt == PORT_A) ? bus.a_margin  : bus.b_margin;

    assign w_cnt_exp    = (r_cnt >= TO_LIMIT);
    assign w_done_match = (r_op == OP_WR) ? bus.ctl_wr_done : bus.ctl_rd_done;
    assign w_ack_evt    = (r_state == ISSUE) && bus.ctl_ack;
    assign w_done_evt   = (r_state == WAIT) && w_done_match;
    assign w_to_evt     = w_cnt_exp && (((r_state == ISSUE) && !bus.ctl_ack) ||
                                        ((r_state == WAIT) && !w_done_match));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_any) w_next_state = ISSUE;
            ISSUE:   if (w_ack_evt) w_next_state = WAIT;
                     else if (w_to_evt) w_next_state = IDLE;
            WAIT:    if (w_done_evt || w_to_evt) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_ctl_wr     = (r_state == ISSUE) && (r_op == OP_WR);
        w_ctl_rd     = (r_state == ISSUE) && (r_op == OP_RD);
        w_ctl_margin = (r_state == ISSUE) && r_margin;
        w_ctl_data   = (r_state == ISSUE) ? r_data : '0;
        w_busy       = (r_state != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt        <= PORT_A;
            r_op         <= OP_WR;
            r_data       <= '0;
            r_margin     <= 1'b0;
            r_cnt        <= '0;
            r_mask_a     <= 1'b0;
            r_mask_b     <= 1'b0;
            r_a_ack      <= 1'b0;
            r_a_wr_done  <= 1'b0;
            r_a_rd_done  <= 1'b0;
            r_a_err      <= 1'b0;
            r_b_ack      <= 1'b0;
            r_b_wr_done  <= 1'b0;
            r_b_rd_done  <= 1'b0;
            r_b_err      <= 1'b0;
            r_a_data_out <= '0;
            r_b_data_out <= '0;
        end else begin
            if (r_state == IDLE && w_any) begin
                r_gnt    <= w_gnt;
                r_op     <= w_sel_wr ? OP_WR : OP_RD;
                r_data   <= w_sel_data;
                r_margin <= w_sel_margin;
            end
            // Held at zero while idle, so it starts from zero on entry to ISSUE.
            if (r_state == IDLE)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;

            if (w_ack_evt && r_gnt == PORT_A) r_mask_a <= 1'b1;
            else if (!w_raw_a)                r_mask_a <= 1'b0;
            if (w_ack_evt && r_gnt == PORT_B) r_mask_b <= 1'b1;
            else if (!w_raw_b)                r_mask_b <= 1'b0;

            r_a_ack     <= w_ack_evt && (r_gnt == PORT_A);
            r_b_ack     <= w_ack_evt && (r_gnt == PORT_B);
            r_a_wr_done <= w_done_evt && (r_gnt == PORT_A) && (r_op == OP_WR);
            r_b_wr_done <= w_done_evt && (r_gnt == PORT_B) && (r_op == OP_WR);
            r_a_rd_done <= w_done_evt && (r_gnt == PORT_A) && (r_op == OP_RD);
            r_b_rd_done <= w_done_evt && (r_gnt == PORT_B) && (r_op == OP_RD);
            r_a_err     <= w_to_evt && (r_gnt == PORT_A);
            r_b_err     <= w_to_evt && (r_gnt == PORT_B);

            if (w_done_evt && r_op == OP_RD && r_gnt == PORT_A) r_a_data_out <= bus.ctl_data_out;
            if (w_done_evt && r_op == OP_RD && r_gnt == PORT_B) r_b_data_out <= bus.ctl_data_out;
        end
    end

    assign bus.ctl_wr      = w_ctl_wr;
    assign bus.ctl_rd      = w_ctl_rd;
    assign bus.ctl_margin  = w_ctl_margin;
    assign bus.ctl_data_in = w_ctl_data;
    assign bus.busy        = w_busy;
    assign bus.a_ack       = r_a_ack;
    assign bus.a_wr_done   = r_a_wr_done;
    assign bus.a_rd_done   = r_a_rd_done;
    assign bus.a_err       = r_a_err;
    assign bus.a_data_out  = r_a_data_out;
    assign bus.b_ack       = r_b_ack;
    assign bus.b_wr_done   = r_b_wr_done;
    assign bus.b_rd_done   = r_b_rd_done;
    assign bus.b_err       = r_b_err;
    assign bus.b_data_out  = r_b_data_out;
    assign o_dbg_state     = r_state;
endmodule
